dmem_controller: RTL

DMEM_CONTROLLER -- requirements
Module: dmem_controller

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/dmem_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : gpu_pkg                                                         |
// | Brief  : Shared GPU types: data-memory controller states, bus defaults.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package gpu_pkg;

    localparam int GPU_ADDR_BITS = 8;
    localparam int GPU_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } dmem_state_e;

    // Index width that stays legal for a single-requester configuration.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arbiter                                                      |
// | Brief  : Combinational round-robin pick, searching upward from rr_ptr.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_BITS = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_BITS-1:0] rr_ptr_i,
    output logic [ID_BITS-1:0] grant_id_o,
    output logic               grant_valid_o
);

    int               idx_int;
    logic [ID_BITS-1:0] idx_w;

    always_comb begin
        grant_id_o    = '0;
        grant_valid_o = 1'b0;
        idx_int       = 0;
        idx_w         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_int = int'(rr_ptr_i) + i;
            if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
            idx_w = ID_BITS'(idx_int);
            if (!grant_valid_o && req_i[idx_w]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = idx_w;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dmem_controller                                                 |
// | Brief  : Arbitrates N LSU ports onto one memory, one transaction a time. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_controller
    import gpu_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = GPU_ADDR_BITS,
    parameter int DATA_BITS     = GPU_DATA_BITS,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic                                      mem_read_valid,
    output logic [ADDR_BITS-1:0]                      mem_read_address,
    input  logic                                      mem_read_ready,
    input  logic [DATA_BITS-1:0]                      mem_read_data,
    output logic                                      mem_write_valid,
    output logic [ADDR_BITS-1:0]                      mem_write_address,
    output logic [DATA_BITS-1:0]                      mem_write_data,
    input  logic                                      mem_write_ready,
    output logic                                      busy
);

    localparam int ID_BITS = id_width(NUM_CONSUMERS);

    dmem_state_e                            state_q, state_d;
    logic [ID_BITS-1:0]                     id_q, id_d, rr_ptr_q, rr_ptr_d;
    logic                                   mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]                   mem_read_address_q, mem_read_address_d;
    logic                                   mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]                   mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]                   mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]               read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]               write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
    logic                                   busy_q;

    logic [NUM_CONSUMERS-1:0]               req_w;
    logic [ID_BITS-1:0]                     grant_id_w;
    logic                                   grant_valid_w;

    // Without write support a pending write must not win arbitration.
    generate
        if (WRITE_ENABLE != 0) begin : g_req_rw
            assign req_w = consumer_read_valid | consumer_write_valid;
        end else begin : g_req_ro
            assign req_w = consumer_read_valid;
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_CONSUMERS),
        .ID_BITS (ID_BITS)
    ) u_arb (
        .req_i         (req_w),
        .rr_ptr_i      (rr_ptr_q),
        .grant_id_o    (grant_id_w),
        .grant_valid_o (grant_valid_w)
    );

    always_comb begin
        state_d             = state_q;
        id_d                = id_q;
        rr_ptr_d            = rr_ptr_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        read_data_d         = read_data_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_w) begin
                    id_d     = grant_id_w;
                    rr_ptr_d = (int'(grant_id_w) == NUM_CONSUMERS - 1) ?
                               '0 : grant_id_w + ID_BITS'(1);
                    // Read wins when a port raises both requests together.
                    if (consumer_read_valid[grant_id_w]) begin
                        state_d            = READ_WAIT;
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[grant_id_w];
                    end else if (WRITE_ENABLE != 0) begin
                        state_d             = WRITE_WAIT;
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[grant_id_w];
                        mem_write_data_d    = consumer_write_data[grant_id_w];
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d  = 1'b0;
                    read_data_d[id_q] = mem_read_data;
                    read_ready_d      = '0;
                    read_ready_d[id_q] = 1'b1;
                    state_d           = READ_RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d   = 1'b0;
                    write_ready_d       = '0;
                    write_ready_d[id_q] = 1'b1;
                    state_d             = WRITE_RELAY;
                end
            end
            READ_RELAY: begin
                if (!consumer_read_valid[id_q]) begin
                    read_ready_d = '0;
                    state_d      = IDLE;
                end
            end
            WRITE_RELAY: begin
                if (!consumer_write_valid[id_q]) begin
                    write_ready_d = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            id_q                <= '0;
            rr_ptr_q            <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            id_q                <= id_d;
            rr_ptr_q            <= rr_ptr_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
            busy_q              <= (state_d != IDLE);
        end
    end

    assign consumer_read_ready = read_ready_q;
    assign consumer_read_data  = read_data_q;
    assign mem_read_valid      = mem_read_valid_q;
    assign mem_read_address    = mem_read_address_q;
    assign busy                = busy_q;

    generate
        if (WRITE_ENABLE != 0) begin : g_write_out
            assign consumer_write_ready = write_ready_q;
            assign mem_write_valid      = mem_write_valid_q;
            assign mem_write_address    = mem_write_address_q;
            assign mem_write_data       = mem_write_data_q;
        end else begin : g_no_write_out
            assign consumer_write_ready = '0;
            assign mem_write_valid      = 1'b0;
            assign mem_write_address    = '0;
            assign mem_write_data       = '0;
        end
    endgenerate

endmodule
`default_nettype wire
